// File: rtl/npu_conv_sequencer_pkg.sv
// CV-X-IF interface types plus the NPU convolution sequencer additions:
// opcode, funct3 operations, sequencer state codes and datapath control bundles.
package npu_conv_sequencer_pkg;

  localparam logic [6:0] NPU_OPCODE  = 7'b0001011;
  localparam logic [5:0] EXC_ILLEGAL = 6'd2;

  typedef enum logic [2:0] {
    OP_CFG_ADDR = 3'd0,
    OP_CFG_DIM  = 3'd1,
    OP_START    = 3'd2,
    OP_STATUS   = 3'd3
  } npu_op_e;

  typedef logic [2:0] seq_state_e;
  localparam seq_state_e ST_IDLE        = 3'd0;
  localparam seq_state_e ST_WAIT_COMMIT = 3'd1;
  localparam seq_state_e ST_LOAD_W      = 3'd2;
  localparam seq_state_e ST_LOAD_I      = 3'd3;
  localparam seq_state_e ST_EXEC        = 3'd4;
  localparam seq_state_e ST_RESULT      = 3'd5;

  typedef struct packed {
    logic [31:0]      instr;
    logic [3:0]       id;
    logic [1:0][31:0] rs;
    logic [1:0]       rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [3:0] id;
    logic       commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } x_result_t;

  typedef struct packed {
    logic [31:0] W_addr;
    logic [31:0] I_addr;
    logic [31:0] R_addr;
    logic [15:0] I_height;
    logic [15:0] I_width;
    logic [15:0] I_kernels;
    logic [15:0] I_channels;
    logic [15:0] W_height;
    logic [15:0] W_width;
    logic [15:0] W_kernels;
    logic [15:0] W_channels;
    logic [15:0] stride;
    logic        padding;
  } convolution;

  typedef struct packed {
    logic loadw;
    logic loadi;
    logic load_start;
    logic execute;
    logic we;
  } cntr;

  typedef struct packed {
    logic weights_start;
    logic weights_valid;
    logic inputs_start;
  } w_load;

  // Legal custom-0 encodings; unused CFG_ADDR/CFG_DIM selector codes are rejected.
  function automatic logic npu_decode_ok(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    if (instr[6:0] == NPU_OPCODE) begin
      case (instr[14:12])
        3'd0:       ok = (instr[26:25] != 2'b11);
        3'd1:       ok = (instr[27:25] <= 3'd4);
        3'd2, 3'd3: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/npu_conv_sequencer_timer.sv
// Phase watchdog and saturating run-cycle counter for the convolution sequencer.
module npu_phase_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_run,
  input  logic        clear_phase,
  input  logic        enable,
  output logic [31:0] run_cnt,
  output logic        timeout
);

  localparam int PW = $clog2(TIMEOUT + 1);

  logic [PW-1:0] phase_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      if (clear_run) begin
        run_cnt <= '0;
      end else if (enable && run_cnt != '1) begin
        run_cnt <= run_cnt + 32'd1;
      end
      if (clear_phase) begin
        phase_cnt <= '0;
      end else if (enable && phase_cnt != PW'(TIMEOUT)) begin
        phase_cnt <= phase_cnt + PW'(1);
      end
    end
  end

  // Fires during the TIMEOUT-th cycle of a phase, so a phase lasts at most TIMEOUT cycles.
  assign timeout = enable && (phase_cnt == PW'(TIMEOUT - 1));

endmodule

// File: rtl/npu_conv_sequencer.sv
// CV-X-IF front end: decodes custom-0 ops, latches layer config on commit and
// sequences weight load -> input load -> execute, reporting cycles or an exception.
module npu_conv_sequencer
  import npu_conv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 65535,
  parameter logic [5:0]  EXC_TIMEOUT = 6'd24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          x_issue_valid_i,
  output logic          x_issue_ready_o,
  input  x_issue_req_t  x_issue_req_i,
  output x_issue_resp_t x_issue_resp_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output convolution    conv_cfg_o,
  output cntr           cntr_o,
  output w_load         wload_o,
  input  logic          weights_done_i,
  input  logic          inputs_done_i,
  input  logic          exec_done_i,
  output logic          busy_o,
  output seq_state_e    state_o
);

  // Valid/ready: issue transfers when x_issue_valid_i && x_issue_ready_o; a result
  // transfers when x_result_valid_o && x_result_ready_i. Valid payloads stay stable.

  seq_state_e  state, state_next;
  npu_op_e     funct3, op_q;
  logic [2:0]  f7_q;
  logic [4:0]  rd_q;
  logic [3:0]  id_q;
  logic [31:0] rs0_q;
  logic [15:0] rs1_q;
  logic        wb_q, exc_q, phase_first;
  logic [5:0]  exccode_q;
  logic        issue_fire, commit_hit, kernels_zero, in_phase, phase_done;
  logic        phase_timeout, timeout;
  logic [31:0] run_cnt;
  logic        unused;

  assign funct3 = npu_op_e'(x_issue_req_i.instr[14:12]);
  assign unused = ^{x_issue_req_i.instr[31:28], x_issue_req_i.instr[24:15], x_issue_req_i.rs[1][31:16]};

  always_comb begin
    x_issue_resp_o           = '0;
    x_issue_resp_o.accept    = npu_decode_ok(x_issue_req_i.instr) && (x_issue_req_i.rs_valid == 2'b11);
    x_issue_resp_o.writeback = x_issue_resp_o.accept && (funct3 == OP_START || funct3 == OP_STATUS);
  end

  assign x_issue_ready_o = (state == ST_IDLE) && !rst_i;
  assign issue_fire      = x_issue_valid_i && x_issue_ready_o && x_issue_resp_o.accept;
  assign commit_hit      = x_commit_valid_i && (x_commit_i.id == id_q);
  assign kernels_zero    = (conv_cfg_o.I_kernels == 16'd0) || (conv_cfg_o.W_kernels == 16'd0);
  assign in_phase        = (state == ST_LOAD_W) || (state == ST_LOAD_I) || (state == ST_EXEC);
  assign phase_timeout   = in_phase && timeout && !phase_done;

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_LOAD_W: phase_done = weights_done_i;
      ST_LOAD_I: phase_done = inputs_done_i;
      ST_EXEC:   phase_done = exec_done_i;
      default:   phase_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue_fire) state_next = ST_WAIT_COMMIT;
      ST_WAIT_COMMIT: begin
        if (commit_hit) begin
          if (x_commit_i.commit_kill)  state_next = ST_IDLE;
          else if (op_q == OP_STATUS)  state_next = ST_RESULT;
          else if (op_q == OP_START)   state_next = kernels_zero ? ST_RESULT : ST_LOAD_W;
          else                         state_next = ST_IDLE;
        end
      end
      ST_LOAD_W: if (phase_done) state_next = ST_LOAD_I; else if (timeout) state_next = ST_RESULT;
      ST_LOAD_I: if (phase_done) state_next = ST_EXEC;   else if (timeout) state_next = ST_RESULT;
      ST_EXEC:   if (phase_done || timeout) state_next = ST_RESULT;
      ST_RESULT: if (x_result_ready_i) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  npu_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_run   ((state == ST_WAIT_COMMIT) && (state_next == ST_LOAD_W)),
    .clear_phase (state_next != state),
    .enable      (in_phase),
    .run_cnt     (run_cnt),
    .timeout     (timeout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      phase_first <= 1'b0;
      op_q        <= OP_CFG_ADDR;
      f7_q        <= '0;
      rd_q        <= '0;
      id_q        <= '0;
      rs0_q       <= '0;
      rs1_q       <= '0;
      wb_q        <= 1'b0;
      exc_q       <= 1'b0;
      exccode_q   <= '0;
      conv_cfg_o  <= '0;
    end else begin
      state       <= state_next;
      phase_first <= (state_next != state);
      if (issue_fire) begin
        op_q      <= funct3;
        f7_q      <= x_issue_req_i.instr[27:25];
        rd_q      <= x_issue_req_i.instr[11:7];
        id_q      <= x_issue_req_i.id;
        rs0_q     <= x_issue_req_i.rs[0];
        rs1_q     <= x_issue_req_i.rs[1][15:0];
        wb_q      <= x_issue_resp_o.writeback;
        exc_q     <= 1'b0;
        exccode_q <= '0;
      end
      if (state == ST_WAIT_COMMIT && commit_hit && !x_commit_i.commit_kill) begin
        case (op_q)
          OP_CFG_ADDR: begin
            case (f7_q[1:0])
              2'd0:    conv_cfg_o.W_addr <= rs0_q;
              2'd1:    conv_cfg_o.I_addr <= rs0_q;
              2'd2:    conv_cfg_o.R_addr <= rs0_q;
              default: ;
            endcase
          end
          OP_CFG_DIM: begin
            case (f7_q)
              3'd0: begin conv_cfg_o.I_height  <= rs0_q[15:0]; conv_cfg_o.I_width    <= rs1_q; end
              3'd1: begin conv_cfg_o.I_kernels <= rs0_q[15:0]; conv_cfg_o.I_channels <= rs1_q; end
              3'd2: begin conv_cfg_o.W_height  <= rs0_q[15:0]; conv_cfg_o.W_width    <= rs1_q; end
              3'd3: begin conv_cfg_o.W_kernels <= rs0_q[15:0]; conv_cfg_o.W_channels <= rs1_q; end
              3'd4: begin conv_cfg_o.stride    <= rs0_q[15:0]; conv_cfg_o.padding    <= rs1_q[0]; end
              default: ;
            endcase
          end
          OP_START: begin
            if (kernels_zero) begin
              exc_q     <= 1'b1;
              exccode_q <= EXC_ILLEGAL;
            end
          end
          default: ;
        endcase
      end
      if (phase_timeout) begin
        exc_q     <= 1'b1;
        exccode_q <= EXC_TIMEOUT;
      end
    end
  end

  always_comb begin
    x_result_o = '0;
    if (state == ST_RESULT) begin
      x_result_o.id      = id_q;
      x_result_o.rd      = rd_q;
      x_result_o.we      = wb_q && !exc_q;
      x_result_o.exc     = exc_q;
      x_result_o.exccode = exccode_q;
      // The run counter is frozen outside the phases, so it holds the final count here.
      if (op_q == OP_START && !exc_q) x_result_o.data = run_cnt;
    end
  end

  assign x_result_valid_o      = (state == ST_RESULT);
  assign busy_o                = (state != ST_IDLE);
  assign state_o               = state;
  assign cntr_o.loadw          = (state == ST_LOAD_W);
  assign cntr_o.loadi          = (state == ST_LOAD_I);
  assign cntr_o.load_start     = (state == ST_LOAD_W) || (state == ST_LOAD_I);
  assign cntr_o.execute        = (state == ST_EXEC);
  assign cntr_o.we             = (state == ST_EXEC);
  assign wload_o.weights_start = (state == ST_LOAD_W) && phase_first;
  assign wload_o.weights_valid = (state == ST_LOAD_W) && phase_first;
  assign wload_o.inputs_start  = (state == ST_LOAD_I) && phase_first;

endmodule

// File: tb/tb_npu_conv_sequencer.sv
// Directed plus randomized bench for npu_conv_sequencer with a behavioural
// config/result model and immediate-assertion checks.
module tb_npu_conv_sequencer;
  import npu_conv_sequencer_pkg::*;

  localparam int RW = $bits(x_result_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          x_issue_valid, x_issue_ready, x_commit_valid, x_result_valid, x_result_ready;
  x_issue_req_t  x_issue_req;
  x_issue_resp_t x_issue_resp;
  x_commit_t     x_commit;
  x_result_t     x_result;
  convolution    conv_cfg;
  cntr           cntr_v;
  w_load         wload;
  logic          weights_done, inputs_done, exec_done, busy;
  seq_state_e    state;

  int checks = 0;
  int errors = 0;
  convolution m_cfg;
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  npu_conv_sequencer #(.TIMEOUT(16), .EXC_TIMEOUT(6'd24)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .x_issue_valid_i  (x_issue_valid),
    .x_issue_ready_o  (x_issue_ready),
    .x_issue_req_i    (x_issue_req),
    .x_issue_resp_o   (x_issue_resp),
    .x_commit_valid_i (x_commit_valid),
    .x_commit_i       (x_commit),
    .x_result_valid_o (x_result_valid),
    .x_result_ready_i (x_result_ready),
    .x_result_o       (x_result),
    .conv_cfg_o       (conv_cfg),
    .cntr_o           (cntr_v),
    .wload_o          (wload),
    .weights_done_i   (weights_done),
    .inputs_done_i    (inputs_done),
    .exec_done_i      (exec_done),
    .busy_o           (busy),
    .state_o          (state)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'b0001011};
  endfunction

  function automatic logic exp_accept(input logic [31:0] ins, input logic [1:0] rsv);
    logic legal;
    case (ins[14:12])
      3'd0:       legal = ins[26:25] inside {2'd0, 2'd1, 2'd2};
      3'd1:       legal = ins[27:25] inside {[3'd0:3'd4]};
      3'd2, 3'd3: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
    return legal && (ins[6:0] == 7'b0001011) && (rsv == 2'b11);
  endfunction

  task automatic model_cfg(input logic [31:0] ins, input logic [31:0] rs0, input logic [31:0] rs1);
    if (ins[14:12] == 3'd0) begin
      case (ins[26:25])
        2'd0:    m_cfg.W_addr = rs0;
        2'd1:    m_cfg.I_addr = rs0;
        2'd2:    m_cfg.R_addr = rs0;
        default: ;
      endcase
    end else begin
      case (ins[27:25])
        3'd0:    begin m_cfg.I_height  = rs0[15:0]; m_cfg.I_width    = rs1[15:0]; end
        3'd1:    begin m_cfg.I_kernels = rs0[15:0]; m_cfg.I_channels = rs1[15:0]; end
        3'd2:    begin m_cfg.W_height  = rs0[15:0]; m_cfg.W_width    = rs1[15:0]; end
        3'd3:    begin m_cfg.W_kernels = rs0[15:0]; m_cfg.W_channels = rs1[15:0]; end
        3'd4:    begin m_cfg.stride    = rs0[15:0]; m_cfg.padding    = rs1[0]; end
        default: ;
      endcase
    end
  endtask

  task automatic expect_result(input string tag, input int hold);
    logic [RW-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, x_result_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_held"}, x_result, e);
      check({tag, "_held_issue_ready"}, x_issue_ready, 1'b0);
      step();
    end
    check(tag, x_result, e);
    x_result_ready = 1'b1;
    step();
    x_result_ready = 1'b0;
    check({tag, "_drained"}, {x_result_valid, busy}, 2'b00);
  endtask

  // One phase lasting d cycles: own done in the last cycle, other dones as strays in cycle 0.
  task automatic run_phase(input int sel, input int d);
    seq_state_e st;
    logic [4:0] ct;
    logic [2:0] wl;
    case (sel)
      0:       begin st = ST_LOAD_W; ct = 5'b10100; wl = 3'b110; end
      1:       begin st = ST_LOAD_I; ct = 5'b01100; wl = 3'b001; end
      default: begin st = ST_EXEC;   ct = 5'b00011; wl = 3'b000; end
    endcase
    check("phase_state", state, st);
    check("phase_cntr", cntr_v, ct);
    check("phase_first_pulse", wload, wl);
    for (int c = 0; c < d; c++) begin
      if (c == d - 1) begin
        weights_done = (sel == 0);
        inputs_done  = (sel == 1);
        exec_done    = (sel == 2);
      end else if (c == 0) begin
        weights_done = (sel != 0);
        inputs_done  = (sel != 1);
        exec_done    = (sel != 2);
      end
      step();
      weights_done = 1'b0;
      inputs_done  = 1'b0;
      exec_done    = 1'b0;
      if (c == 0 && d > 1) begin
        check("start_pulse_one_cycle", wload, 3'b000);
        check("stray_done_ignored", state, st);
      end
    end
  endtask

  // dw == 0 withholds weights_done; de < 0 resets in the first EXEC cycle.
  task automatic do_op(input logic [31:0] ins, input logic [31:0] rs0, input logic [31:0] rs1,
                       input logic [1:0] rsv, input logic kill, input logic stray,
                       input int dw, input int di, input int de, input int hold);
    logic [3:0] id;
    logic       acc, wb;
    logic [2:0] f3;
    x_result_t  e;
    int         n;
    id  = 4'($urandom_range(0, 15));
    f3  = ins[14:12];
    acc = exp_accept(ins, rsv);
    wb  = acc && (f3 == 3'd2 || f3 == 3'd3);
    x_issue_valid        = 1'b1;
    x_issue_req.instr    = ins;
    x_issue_req.id       = id;
    x_issue_req.rs[0]    = rs0;
    x_issue_req.rs[1]    = rs1;
    x_issue_req.rs_valid = rsv;
    #1;
    check("issue_ready", x_issue_ready, 1'b1);
    check("issue_resp", x_issue_resp, {acc, wb, 4'b0000});
    step();
    x_issue_valid = 1'b0;
    x_issue_req   = '0;
    if (!acc) begin
      check("reject_stays_idle", {busy, x_issue_ready}, 2'b01);
      return;
    end
    check("wait_commit", state, ST_WAIT_COMMIT);
    if (stray) begin
      x_commit_valid       = 1'b1;
      x_commit.id          = id ^ 4'h5;
      x_commit.commit_kill = 1'($urandom_range(0, 1));
      step();
      x_commit_valid = 1'b0;
      check("foreign_commit_ignored", state, ST_WAIT_COMMIT);
    end
    x_commit_valid       = 1'b1;
    x_commit.id          = id;
    x_commit.commit_kill = kill;
    step();
    x_commit_valid = 1'b0;
    x_commit       = '0;
    if (kill) begin
      check("kill_to_idle", {state, x_result_valid}, {ST_IDLE, 1'b0});
      check("kill_cfg_kept", conv_cfg, m_cfg);
      return;
    end
    e    = '0;
    e.id = id;
    e.rd = ins[11:7];
    if (f3 == 3'd0 || f3 == 3'd1) begin
      model_cfg(ins, rs0, rs1);
      check("cfg_latched", conv_cfg, m_cfg);
      check("cfg_no_result", {x_result_valid, busy}, 2'b00);
    end else if (f3 == 3'd3) begin
      e.we = 1'b1;
      exp_q.push_back(e);
      expect_result("status", hold);
    end else if (m_cfg.I_kernels == 16'd0 || m_cfg.W_kernels == 16'd0) begin
      e.exc     = 1'b1;
      e.exccode = 6'd2;
      exp_q.push_back(e);
      check("illegal_no_pulses", {cntr_v, wload}, 8'h00);
      expect_result("start_illegal", hold);
    end else if (dw == 0) begin
      check("timeout_first_pulse", wload, 3'b110);
      n = 0;
      for (int i = 0; i < 40 && !x_result_valid; i++) begin
        step();
        n++;
      end
      check("timeout_cycles", n, 16);
      check("timeout_ctrl_zero", {cntr_v, wload}, 8'h00);
      e.exc     = 1'b1;
      e.exccode = 6'd24;
      exp_q.push_back(e);
      expect_result("start_timeout", hold);
    end else begin
      run_phase(0, dw);
      run_phase(1, di);
      if (de < 0) begin
        check("reset_in_exec", state, ST_EXEC);
        rst = 1'b1;
        step();
        check("reset_outs_a", {x_issue_ready, x_issue_resp, x_result_valid, x_result, busy, state}, '0);
        check("reset_outs_b", {conv_cfg, cntr_v, wload}, '0);
        m_cfg = '0;
        rst   = 1'b0;
        step();
        step();
        check("reset_recovered", {x_issue_ready, busy, x_result_valid}, 3'b100);
        return;
      end
      run_phase(2, de);
      e.we   = 1'b1;
      e.data = 32'(dw + di + de);
      exp_q.push_back(e);
      expect_result("start_run", hold);
    end
  endtask

  initial begin
    int r;
    logic [31:0] ins, a, b;
    logic [1:0]  rsv;
    rst            = 1'b1;
    x_issue_valid  = 1'b0;
    x_issue_req    = '0;
    x_commit_valid = 1'b0;
    x_commit       = '0;
    x_result_ready = 1'b0;
    weights_done   = 1'b0;
    inputs_done    = 1'b0;
    exec_done      = 1'b0;
    m_cfg          = '0;
    step();
    step();
    check("rst_outs_a", {x_issue_ready, x_issue_resp, x_result_valid, x_result, busy, state}, '0);
    check("rst_outs_b", {conv_cfg, cntr_v, wload}, '0);
    rst = 1'b0;
    step();
    check("idle_ready", {x_issue_ready, busy}, 2'b10);

    do_op(mk(7'd0, 3'd1, 5'd0), 32'd8, 32'd8, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    check("i_height_width", {conv_cfg.I_height, conv_cfg.I_width}, {16'd8, 16'd8});
    do_op(mk(7'd1, 3'd0, 5'd0), 32'h1000, 32'd0, 2'b11, 1'b1, 1'b0, 0, 0, 0, 0);
    check("killed_i_addr", conv_cfg.I_addr, 32'd0);
    do_op(mk(7'd1, 3'd1, 5'd0), 32'd4, 32'd3, 2'b11, 1'b0, 1'b1, 0, 0, 0, 0);
    do_op(mk(7'd3, 3'd1, 5'd0), 32'd0, 32'd2, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd0, 3'd2, 5'd3), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 3, 5, 10, 0);
    do_op(mk(7'd3, 3'd1, 5'd0), 32'd2, 32'd2, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd4, 3'd1, 5'd0), 32'd2, 32'd1, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd2, 3'd0, 5'd0), 32'hCAFE_0000, 32'd0, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd0, 3'd2, 5'd10), 32'd0, 32'd0, 2'b11, 1'b0, 1'b1, 3, 5, 10, 0);
    do_op(mk(7'd0, 3'd2, 5'd11), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 2, 1, 16, 0);
    do_op(mk(7'd0, 3'd3, 5'd7), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 0, 0, 0, 5);
    do_op(mk(7'd0, 3'd2, 5'd12), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd0, 3'd2, 5'd0) ^ 32'h1, 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1, 1, 1, 0);
    do_op(mk(7'd0, 3'd5, 5'd0), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1, 1, 1, 0);
    do_op(mk(7'd3, 3'd0, 5'd0), 32'd9, 32'd0, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd5, 3'd1, 5'd0), 32'd9, 32'd9, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd0, 3'd3, 5'd1), 32'd0, 32'd0, 2'b01, 1'b0, 1'b0, 0, 0, 0, 0);
    do_op(mk(7'd0, 3'd2, 5'd13), 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 2, 2, -1, 0);

    for (int it = 0; it < 30; it++) begin
      r   = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, 3));
      b   = 32'($urandom_range(0, 3));
      rsv = 2'b11;
      if (r <= 3)      ins = mk(7'($urandom_range(0, 7)), 3'd1, 5'($urandom_range(0, 31)));
      else if (r == 4) begin
        ins = mk(7'($urandom_range(0, 3)), 3'd0, 5'($urandom_range(0, 31)));
        a   = $urandom;
      end
      else if (r == 5) ins = mk(7'd0, 3'd3, 5'($urandom_range(0, 31)));
      else if (r <= 7) ins = mk(7'd0, 3'd2, 5'($urandom_range(0, 31)));
      else if (r == 8) ins = mk(7'd0, 3'($urandom_range(4, 7)), 5'd1);
      else begin
        ins = mk(7'd0, 3'd3, 5'd1);
        rsv = 2'($urandom_range(0, 2));
      end
      do_op(ins, a, b, rsv, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, 16)), int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
            int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
